// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand issue path: default widths,
// timeout and the issue-controller state encoding.
package fpu_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int TIMER_W     = 8;

    typedef enum logic [1:0] {
        OI_IDLE = 2'b00,
        OI_WAIT = 2'b01,
        OI_ERR  = 2'b10
    } oi_state_t;

    // FIFO entries carry opa in the upper half and opb in the lower half.
    function automatic logic [2*DATA_W_DEF-1:0] pack_pair(
        input logic [DATA_W_DEF-1:0] a,
        input logic [DATA_W_DEF-1:0] b
    );
        return {a, b};
    endfunction
endpackage

// File: rtl/fpu_operand_issue_if.sv
// Bundle of the operand-stream, FPU handshake and result signals.
// slave is the issue block's view; master is the environment driving it.
interface fpu_operand_issue_if
    import fpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              oi_pair_valid;
    logic [DATA_W-1:0] oi_opa;
    logic [DATA_W-1:0] oi_opb;
    logic              oi_pair_ready;
    logic [LW-1:0]     oi_level;
    logic [DATA_W-1:0] oi_fpu_opa;
    logic [DATA_W-1:0] oi_fpu_opb;
    logic              oi_fpu_start;
    logic              oi_fpu_done;
    logic [DATA_W-1:0] oi_fpu_result;
    logic [DATA_W-1:0] oi_result;
    logic              oi_result_valid;
    logic              oi_busy;
    logic              oi_timeout_err;

    modport slave (
        input  oi_pair_valid, oi_opa, oi_opb, oi_fpu_done, oi_fpu_result,
        output oi_pair_ready, oi_level, oi_fpu_opa, oi_fpu_opb, oi_fpu_start,
               oi_result, oi_result_valid, oi_busy, oi_timeout_err
    );

    modport master (
        output oi_pair_valid, oi_opa, oi_opb, oi_fpu_done, oi_fpu_result,
        input  oi_pair_ready, oi_level, oi_fpu_opa, oi_fpu_opb, oi_fpu_start,
               oi_result, oi_result_valid, oi_busy, oi_timeout_err
    );
endinterface

// File: rtl/operand_fifo.sv
// Synchronous FIFO for packed operand pairs; show-ahead read of the head.
module operand_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Full refuses a push even when a pop lands on the same edge.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fpu_operand_issue.sv
// Buffers operand pairs from memory and issues them one at a time to the
// FPU with a start/done handshake, flagging an unresponsive FPU.
module fpu_operand_issue
    import fpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                oi_clk,
    input  logic                oi_reset,
    fpu_operand_issue_if.slave  bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMEOUT - 1);

    oi_state_t           state, state_n;
    logic                pop;
    logic [2*DATA_W-1:0] head;
    logic [LW-1:0]       count;
    logic                full;
    logic                empty;
    logic [TIMER_W-1:0]  timer;
    logic [DATA_W-1:0]   fpu_opa;
    logic [DATA_W-1:0]   fpu_opb;
    logic                fpu_start;
    logic [DATA_W-1:0]   result;
    logic                result_valid;
    logic                timeout_err;

    operand_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (oi_clk),
        .rst   (oi_reset),
        .push  (bus.oi_pair_valid),
        .pop   (pop),
        .din   ({bus.oi_opa, bus.oi_opb}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge oi_clk or posedge oi_reset) begin
        if (oi_reset) state <= OI_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            OI_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = OI_WAIT;
                end
            end
            OI_WAIT: begin
                if (bus.oi_fpu_done)  state_n = OI_IDLE;
                else if (timer == TMAX) state_n = OI_ERR;
            end
            default: state_n = OI_IDLE;
        endcase
    end

    always_ff @(posedge oi_clk or posedge oi_reset) begin
        if (oi_reset) begin
            timer        <= '0;
            fpu_opa      <= '0;
            fpu_opb      <= '0;
            fpu_start    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            fpu_start    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                OI_IDLE: begin
                    if (!empty) begin
                        fpu_opa   <= head[2*DATA_W-1:DATA_W];
                        fpu_opb   <= head[DATA_W-1:0];
                        fpu_start <= 1'b1;
                        timer     <= '0;
                    end
                end
                OI_WAIT: begin
                    if (bus.oi_fpu_done) begin
                        result       <= bus.oi_fpu_result;
                        result_valid <= 1'b1;
                    end else if (timer == TMAX) begin
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.oi_pair_ready   = !full;
    assign bus.oi_level        = count;
    assign bus.oi_fpu_opa      = fpu_opa;
    assign bus.oi_fpu_opb      = fpu_opb;
    assign bus.oi_fpu_start    = fpu_start;
    assign bus.oi_result       = result;
    assign bus.oi_result_valid = result_valid;
    assign bus.oi_busy         = (state == OI_WAIT);
    assign bus.oi_timeout_err  = timeout_err;
endmodule

// File: doc/fpu_operand_issue.md
Name: fpu_operand_issue

Overview:
- Downstream neighbour of the memory controller.
- Accepts 32-bit operand pairs (opa/opb) streamed out of RAM and buffers them in a small FIFO.
- Issues one pair at a time to the FPU core with a start/done handshake, then returns each result with a one-cycle valid strobe.
- Decouples memory-read bursts from variable FPU latency and flags a hung FPU with a timeout.

Parameters:
- DATA_W, 32, operand and result width.
- DEPTH, 4, FIFO depth in operand pairs; power of 2, minimum 2.
- TIMEOUT, 255, maximum cycles in WAIT without oi_fpu_done; range 1..255.

Ports:
- oi_clk  in  1  clock; all logic on rising edge.
- oi_reset  in  1  asynchronous, active-high reset.
- oi_pair_valid  in  1  operand pair present on oi_opa/oi_opb.
- oi_opa  in  DATA_W  operand A from the memory controller.
- oi_opb  in  DATA_W  operand B from the memory controller.
- oi_pair_ready  out  1  FIFO can accept a pair.
- oi_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- oi_fpu_opa  out  DATA_W  operand A to the FPU; held stable through WAIT.
- oi_fpu_opb  out  DATA_W  operand B to the FPU; held stable through WAIT.
- oi_fpu_start  out  1  one-cycle start pulse to the FPU.
- oi_fpu_done  in  1  FPU result valid.
- oi_fpu_result  in  DATA_W  FPU result.
- oi_result  out  DATA_W  captured result.
- oi_result_valid  out  1  one-cycle strobe; oi_result is new.
- oi_busy  out  1  high in WAIT.
- oi_timeout_err  out  1  sticky; the FPU failed to answer within TIMEOUT.

Behaviour:
- Reset: async, active-high. FIFO emptied; pointers and count = 0; state = IDLE.
  - oi_fpu_start, oi_result_valid, oi_busy, oi_timeout_err = 0.
  - oi_fpu_opa, oi_fpu_opb, oi_result = 0.
  - Reset mid-WAIT abandons the in-flight operation; no result is ever produced for it.
- FIFO:
  - Push when oi_pair_valid && oi_pair_ready.
  - oi_pair_ready = (count != DEPTH), a combinational function of the registered count.
  - oi_pair_valid while not ready is ignored: the data is dropped, and the upstream block must hold it.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - Simultaneous push and pop: both occur and count is unchanged.
  - At full, push is refused that cycle even if a pop happens on the same edge.
  - Pop only from IDLE when count != 0.
  - FIFO order is strictly preserved.
- FSM states: IDLE, WAIT, ERR.
  - IDLE, count != 0: at the next edge, pop the head; load oi_fpu_opa/oi_fpu_opb; oi_fpu_start <= 1; timer <= 0; go to WAIT.
  - IDLE, count == 0: stay; oi_fpu_done is ignored.
  - WAIT, general: oi_fpu_start <= 0, so start is high exactly one cycle. oi_busy = 1.
  - WAIT, oi_fpu_done sampled high (including the first WAIT edge): oi_result <= oi_fpu_result; oi_result_valid <= 1 for one cycle; go to IDLE.
  - WAIT, no done: timer increments. When timer == TIMEOUT-1 and done is still low: oi_timeout_err <= 1; go to ERR.
  - ERR: one cycle, then IDLE. No result_valid for the dropped pair. The FIFO is untouched and processing continues.
  - oi_timeout_err clears only on reset.
- Latency:
  - Pair pushed at edge E0 into an empty FIFO while IDLE → oi_fpu_start high after E1.
  - oi_fpu_done sampled at edge Ek → oi_result_valid high after Ek.
  - Next issue at Ek+1 at the earliest. Sustained throughput: one pair per (FPU latency + 2) cycles.
- Arithmetic: timer is 8 bits. Count is clog2(DEPTH)+1 bits, so the full and empty states are distinguishable.

Decomposition:
- Shared package fpu_pkg holds:
  - the DATA_W default;
  - the oi state encoding (IDLE=2'b00, WAIT=2'b01, ERR=2'b10);
  - the TIMEOUT default.
- One sub-module: operand_fifo, a synchronous FIFO.
  - Width 2*DATA_W, {opa,opb}; depth DEPTH.
  - Ports: push, pop, data in/out, count, full, empty.
  - Same clock and async active-high reset as the parent.
- The FSM, timer and result capture stay in fpu_operand_issue.

Test Plan:
- Reset check: assert oi_reset mid-cycle → every output is 0 immediately; oi_pair_ready=1; oi_level=0.
- Single op: push opa=0x3F800000, opb=0x40000000; FPU returns done 3 cycles after start with result 0x40400000.
  - Required: start high exactly one cycle, one edge after the push.
  - Required: fpu operands stable through WAIT.
  - Required: oi_result=0x40400000 with result_valid for one cycle.
- Back-pressure: hold done low, push 5 pairs with opa=1..5.
  - First pair issues.
  - Level reaches 4 and ready drops; the 6th push attempt is ignored.
  - After done pulses, results are in order 1..5, none lost.
- Simultaneous push/pop: level=1, IDLE, push on the same edge as the pop → level stays 1, and the popped pair is the older one.
- Timeout: issue a pair and never assert done.
  - After 255 WAIT cycles, oi_timeout_err=1 (sticky); no result_valid.
  - The next queued pair issues 2 cycles later.
- Reset mid-WAIT: reset while busy, then assert done → no result_valid; level=0; state IDLE.
